io_input_port: RTL and testbench

//  Memory-mapped input side of the CPU I/O bus; counterpart to the output-port block.

---
 rtl/io_map_pkg.sv | 22 ++
 rtl/io_input_port_if.sv | 9 +
 rtl/io_debounce.sv | 73 +++++++
 rtl/io_input_port.sv | 101 ++++++++++
 tb/tb_io_input_port.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/io_map_pkg.sv
// I/O page address map shared by the input and output port blocks, plus debounce defaults.
package io_map_pkg;

  // Word indexes (addr[7:2]) on the output page.
  localparam logic [5:0] ADDR_OUT_PORT0 = 6'b100000;
  localparam logic [5:0] ADDR_OUT_PORT1 = 6'b100001;
  localparam logic [5:0] ADDR_OUT_LEDS  = 6'b100010;

  // Word indexes (addr[7:2]) on the input page.
  localparam logic [5:0] ADDR_IN_PORT0  = 6'b110000;
  localparam logic [5:0] ADDR_IN_PORT1  = 6'b110001;
  localparam logic [5:0] ADDR_IN_KEYS   = 6'b110010;
  localparam logic [5:0] ADDR_IN_EDGE   = 6'b110011;
  localparam logic [5:0] ADDR_IN_STATUS = 6'b110100;

  localparam int unsigned DB_CYCLES_DEFAULT = 50000;
  localparam int unsigned DB_W_DEFAULT      = 16;

  // Cycles after reset before key edges may be captured; covers sync fill and prime load.
  localparam logic [2:0] WARM_DONE = 3'd4;

endpackage

// File: rtl/io_input_port_if.sv
// CPU-side I/O load bus: byte address, load strobe and returned read data.
interface io_input_port_if;
  logic [31:0] addr;
  logic        read_io_enable;
  logic [31:0] io_read_data;

  modport master (output addr, output read_io_enable, input io_read_data);
  modport slave  (input addr, input read_io_enable, output io_read_data);
endinterface

// File: rtl/io_debounce.sv
// Per-key two-flop synchroniser with optional stable-count debounce (IO_INPUT_DEBOUNCE_EN).
module io_debounce
  import io_map_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned DB_W      = DB_W_DEFAULT
) (
  input  logic io_clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_db_c
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = key_raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge io_clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef IO_INPUT_DEBOUNCE_EN
  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0] cnt_q, cnt_d;
  logic            acc_q, acc_d;
  logic [1:0]      prime_q, prime_d;

  // After reset the accepted value tracks the sync output directly, so a key
  // held through reset is accepted without a debounce-delayed 0->1 change.
  always_comb begin
    cnt_d   = '0;
    acc_d   = acc_q;
    prime_d = prime_q;
    if (prime_q != 2'd3) begin
      prime_d = prime_q + 2'd1;
      acc_d   = sync2_q;
    end else if (sync2_q != acc_q) begin
      if (cnt_q == CNT_LAST) acc_d = ~acc_q;
      else                   cnt_d = cnt_q + DB_W'(1);
    end
  end

  always_ff @(posedge io_clk) begin
    if (reset) begin
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      prime_q <= 2'd0;
    end else begin
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      prime_q <= prime_d;
    end
  end

  assign key_db_c = acc_q;
`else
  localparam int unsigned UNUSED_DB_CFG = DB_CYCLES + DB_W;

  assign key_db_c = sync2_q;
`endif

endmodule

// File: rtl/io_input_port.sv
// Memory-mapped input port: synced switches, debounced keys (IO_INPUT_DEBOUNCE_EN), edge capture, irq.
module io_input_port
  import io_map_pkg::*;
#(
  parameter int unsigned NKEYS     = 4,
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int unsigned DB_W      = DB_W_DEFAULT
) (
  input  logic              io_clk,
  input  logic              reset,
  io_input_port_if.slave    bus,
  input  logic [31:0]       in_port0,
  input  logic [31:0]       in_port1,
  input  logic [NKEYS-1:0]  key_in,
  output logic              key_irq
);

  logic [NKEYS-1:0] key_db_c;

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    io_debounce #(
      .DB_CYCLES (DB_CYCLES),
      .DB_W      (DB_W)
    ) u_debounce (
      .io_clk   (io_clk),
      .reset    (reset),
      .key_raw  (key_in[i]),
      .key_db_c (key_db_c[i])
    );
  end

  logic [31:0]      p0_s1_q, p0_s1_d, p0_s2_q, p0_s2_d;
  logic [31:0]      p1_s1_q, p1_s1_d, p1_s2_q, p1_s2_d;
  logic [NKEYS-1:0] key_prev_q, key_prev_d;
  logic [NKEYS-1:0] cap_q, cap_d;
  logic [2:0]       warm_q, warm_d;
  logic [31:0]      rd_data_q, rd_data_d;
  logic             key_irq_q, key_irq_d;

  logic [5:0]       sel_c;
  logic [NKEYS-1:0] edge_c;
  logic             clr_c;
  logic             unused_addr_bits_c;

  assign unused_addr_bits_c = ^{bus.addr[31:8], bus.addr[1:0]};

  // Read decode, edge detect and read-to-clear capture.
  always_comb begin
    p0_s1_d    = in_port0;
    p0_s2_d    = p0_s1_q;
    p1_s1_d    = in_port1;
    p1_s2_d    = p1_s1_q;
    key_prev_d = key_db_c;
    warm_d     = (warm_q == WARM_DONE) ? warm_q : warm_q + 3'd1;
    sel_c      = bus.addr[7:2];
    edge_c     = (warm_q == WARM_DONE) ? (key_db_c & ~key_prev_q) : '0;
    clr_c      = bus.read_io_enable && (sel_c == ADDR_IN_EDGE);
    // The read returns every set bit, so clearing all of them is exact; new edges still land.
    cap_d      = (clr_c ? '0 : cap_q) | edge_c;
    key_irq_d  = |cap_d;
    rd_data_d  = rd_data_q;
    if (bus.read_io_enable) begin
      case (sel_c)
        ADDR_IN_PORT0:  rd_data_d = p0_s2_q;
        ADDR_IN_PORT1:  rd_data_d = p1_s2_q;
        ADDR_IN_KEYS:   rd_data_d = 32'(key_db_c);
        ADDR_IN_EDGE:   rd_data_d = 32'(cap_q);
        ADDR_IN_STATUS: rd_data_d = {30'b0, key_irq_q, |key_db_c};
        default:        rd_data_d = 32'h0;
      endcase
    end
  end

  always_ff @(posedge io_clk) begin
    if (reset) begin
      p0_s1_q    <= '0;
      p0_s2_q    <= '0;
      p1_s1_q    <= '0;
      p1_s2_q    <= '0;
      key_prev_q <= '0;
      cap_q      <= '0;
      warm_q     <= '0;
      rd_data_q  <= '0;
      key_irq_q  <= 1'b0;
    end else begin
      p0_s1_q    <= p0_s1_d;
      p0_s2_q    <= p0_s2_d;
      p1_s1_q    <= p1_s1_d;
      p1_s2_q    <= p1_s2_d;
      key_prev_q <= key_prev_d;
      cap_q      <= cap_d;
      warm_q     <= warm_d;
      rd_data_q  <= rd_data_d;
      key_irq_q  <= key_irq_d;
    end
  end

  assign bus.io_read_data = rd_data_q;
  assign key_irq          = key_irq_q;

endmodule

// File: tb/tb_io_input_port.sv
// Scoreboard bench for io_input_port: reads queue expected data, a monitor compares returned data.
module tb_io_input_port;

  localparam int unsigned NKEYS     = 4;
  localparam int unsigned DB_CYCLES = 8;
  localparam int unsigned DB_W      = 16;
`ifdef IO_INPUT_DEBOUNCE_EN
  localparam int unsigned KEY_LAT = DB_CYCLES + 1;
`else
  localparam int unsigned KEY_LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      in_port0;
  logic [31:0]      in_port1;
  logic [NKEYS-1:0] key_in;
  logic             key_irq;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] exp_q[$];
  logic [7:0]  addr_q[$];

  io_input_port_if bus();

  always #5 clk = ~clk;

  io_input_port #(
    .NKEYS     (NKEYS),
    .DB_CYCLES (DB_CYCLES),
    .DB_W      (DB_W)
  ) dut (
    .io_clk   (clk),
    .reset    (reset),
    .bus      (bus),
    .in_port0 (in_port0),
    .in_port1 (in_port1),
    .key_in   (key_in),
    .key_irq  (key_irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    addr_q.push_back(a);
    bus.addr           = {24'h0, a};
    bus.read_io_enable = 1'b1;
    wait_cycles(1);
    bus.read_io_enable = 1'b0;
    bus.addr           = '0;
  endtask

  // Monitor: every accepted load is checked on the edge that answers it.
  initial begin : monitor
    logic [7:0]  a;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      if (bus.read_io_enable && !reset) begin
        #2;
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL rd_unexpected: got %h, expected no read", bus.io_read_data);
        end else begin
          a = addr_q.pop_front();
          e = exp_q.pop_front();
          check($sformatf("rd_%h", a), bus.io_read_data, e);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected end of run");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset              = 1'b1;
    in_port0           = '0;
    in_port1           = '0;
    key_in             = '0;
    bus.addr           = '0;
    bus.read_io_enable = 1'b0;
    wait_cycles(3);
    check("reset_rd_data", bus.io_read_data, 32'h0);
    check("reset_irq", {31'b0, key_irq}, 32'h0);
    reset = 1'b0;
    wait_cycles(6);

    // Switch banks.
    in_port0 = 32'hA5A5_0F0F;
    in_port1 = 32'h1234_5678;
    wait_cycles(3);
    do_read(8'hC0, 32'hA5A5_0F0F);
    do_read(8'hC4, 32'h1234_5678);

    // Key0 bounces for 20 cycles, ending low, then holds high.
    for (int i = 0; i < 20; i++) begin
      key_in[0] = ((i / 3) % 2) == 1;
      wait_cycles(1);
    end
    key_in[0] = 1'b1;
`ifdef IO_INPUT_DEBOUNCE_EN
    wait_cycles(9);
    check("db_irq_early", {31'b0, key_irq}, 32'h0);
    wait_cycles(3);
`else
    wait_cycles(12);
`endif
    check("bounce_irq", {31'b0, key_irq}, 32'h1);
    do_read(8'hCC, 32'h1);
    do_read(8'hD0, 32'h1);
    check("clear_irq", {31'b0, key_irq}, 32'h0);

    // Re-arm bit0, then key1 edge lands in the clearing-read cycle.
    key_in[0] = 1'b0;
    wait_cycles(14);
    key_in[0] = 1'b1;
    wait_cycles(14);
    key_in[1] = 1'b1;
    wait_cycles(KEY_LAT + 1);
    do_read(8'hCC, 32'h1);
    check("coincide_irq", {31'b0, key_irq}, 32'h1);
    do_read(8'hCC, 32'h2);
    check("coincide_irq_clr", {31'b0, key_irq}, 32'h0);

    // Held keys do not retrigger.
    wait_cycles(20);
    do_read(8'hCC, 32'h0);

    // Reset in the middle of a debounce count with a capture bit set.
    key_in[3] = 1'b1;
    wait_cycles(14);
    check("key3_irq", {31'b0, key_irq}, 32'h1);
    do_read(8'hC0, 32'hA5A5_0F0F);
    key_in[3] = 1'b0;
    wait_cycles(3);
    reset  = 1'b1;
    key_in = 4'hF;
    wait_cycles(1);
    check("midreset_rd_data", bus.io_read_data, 32'h0);
    check("midreset_irq", {31'b0, key_irq}, 32'h0);
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(20);
    check("post_reset_irq", {31'b0, key_irq}, 32'h0);
    do_read(8'hCC, 32'h0);
    do_read(8'hD0, 32'h1);
    do_read(8'hC8, 32'hF);

    // Unmapped read and a non-read cycle at CCh.
    do_read(8'h30, 32'h0);
    key_in[2] = 1'b0;
    wait_cycles(14);
    key_in[2] = 1'b1;
    wait_cycles(14);
    do_read(8'hC4, 32'h1234_5678);
    bus.addr = 32'h0000_00CC;
    wait_cycles(2);
    bus.addr = '0;
    check("noread_hold", bus.io_read_data, 32'h1234_5678);
    check("noread_irq", {31'b0, key_irq}, 32'h1);
    do_read(8'hCC, 32'h4);

    // One-cycle pulse on key2.
    key_in[2] = 1'b0;
    wait_cycles(14);
    key_in[2] = 1'b1;
    wait_cycles(1);
    key_in[2] = 1'b0;
`ifdef IO_INPUT_DEBOUNCE_EN
    wait_cycles(14);
    do_read(8'hCC, 32'h0);
`else
    wait_cycles(1);
    check("pulse_irq_early", {31'b0, key_irq}, 32'h0);
    wait_cycles(1);
    check("pulse_irq", {31'b0, key_irq}, 32'h1);
    wait_cycles(12);
    do_read(8'hCC, 32'h4);
`endif
    check("final_irq", {31'b0, key_irq}, 32'h0);

    wait_cycles(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
